// File: rtl/soc_irq_pkg.sv
// Shared constants for the SoC interrupt controller: MMIO word map and FSM state encoding.
package soc_irq_pkg;

    localparam int unsigned IRQ_ADDR_W = 2;

    localparam logic [IRQ_ADDR_W-1:0] IRQ_A_PEND = 2'd0;
    localparam logic [IRQ_ADDR_W-1:0] IRQ_A_EN   = 2'd1;
    localparam logic [IRQ_ADDR_W-1:0] IRQ_A_STAT = 2'd2;
    localparam logic [IRQ_ADDR_W-1:0] IRQ_A_SWI  = 2'd3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

endpackage

// File: rtl/soc_irq_arb.sv
// Combinational arbiter: first set bit of req_i searching upward from start_i, wrapping at NUM_SRC.
module soc_irq_arb #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned VEC_W   = 3
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [VEC_W-1:0]   start_i,
    output logic [VEC_W-1:0]   win_o,
    output logic               any_o
);

    int unsigned idx;

    always_comb begin
        win_o = '0;
        any_o = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            idx = (32'(start_i) + i) % NUM_SRC;
            if (!any_o && (|(req_i & (NUM_SRC'(1) << idx)))) begin
                any_o = 1'b1;
                win_o = VEC_W'(idx);
            end
        end
    end

endmodule

// File: rtl/soc_irq_ctrl.sv
// Interrupt controller: edge capture, enable mask, single-winner request/take/done handshake, 4-word MMIO.
// Define IRQ_CTRL_RR_EN for round-robin arbitration; default is fixed lowest-index priority.
module soc_irq_ctrl
    import soc_irq_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned VEC_W   = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NUM_SRC-1:0]    i_src,
    input  logic                  i_sel,
    input  logic                  i_we,
    input  logic [IRQ_ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic [DATA_W-1:0]     o_rdata,
    output logic                  o_irq_req,
    output logic [VEC_W-1:0]      o_irq_vec,
    input  logic                  i_irq_take,
    input  logic                  i_irq_done,
    output logic                  o_in_irq
);

    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] en_q, en_d;
    logic [1:0]         state_q, state_d;
    logic               req_q, req_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [VEC_W-1:0]   act_q, act_d;
    logic               in_irq_q, in_irq_d;

    logic               wr_en;
    logic               take_ok;
    logic [NUM_SRC-1:0] set_bits;
    logic [NUM_SRC-1:0] clr_bits;
    logic [NUM_SRC-1:0] arb_req;
    logic [VEC_W-1:0]   arb_start;
    logic [VEC_W-1:0]   arb_win;
    logic               arb_any;
    logic               unused_wdata;

    assign unused_wdata = ^i_wdata[DATA_W-1:NUM_SRC];

    assign wr_en   = i_sel & i_we;
    assign take_ok = (state_q == ST_REQ) & req_q & i_irq_take;
    assign arb_req = pend_q & en_q;

    // Set events (edge, SWI) are ORed in after clears so a same-cycle set always wins.
    always_comb begin
        set_bits = (i_src & ~src_q);
        clr_bits = '0;
        en_d     = en_q;
        if (wr_en && (i_addr == IRQ_A_SWI)) begin
            set_bits = set_bits | i_wdata[NUM_SRC-1:0];
        end
        if (wr_en && (i_addr == IRQ_A_PEND)) begin
            clr_bits = i_wdata[NUM_SRC-1:0];
        end
        if (wr_en && (i_addr == IRQ_A_EN)) begin
            en_d = i_wdata[NUM_SRC-1:0];
        end
        if (take_ok) begin
            clr_bits = clr_bits | (NUM_SRC'(1) << vec_q);
        end
        pend_d = (pend_q & ~clr_bits) | set_bits;
    end

`ifdef IRQ_CTRL_RR_EN
    logic [VEC_W-1:0] last_q, last_d;

    assign last_d    = take_ok ? vec_q : last_q;
    assign arb_start = (last_q == VEC_W'(NUM_SRC - 1)) ? '0 : last_q + VEC_W'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_q <= VEC_W'(NUM_SRC - 1);
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign arb_start = '0;
`endif

    soc_irq_arb #(
        .NUM_SRC (NUM_SRC),
        .VEC_W   (VEC_W)
    ) u_arb (
        .req_i   (arb_req),
        .start_i (arb_start),
        .win_o   (arb_win),
        .any_o   (arb_any)
    );

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        vec_d    = vec_q;
        act_d    = act_q;
        in_irq_d = in_irq_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    vec_d   = arb_win;
                end
            end
            ST_REQ: begin
                if (take_ok) begin
                    state_d  = ST_SERVICE;
                    req_d    = 1'b0;
                    act_d    = vec_q;
                    in_irq_d = 1'b1;
                end else if (!arb_any) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end else begin
                    vec_d = arb_win;
                end
            end
            ST_SERVICE: begin
                if (i_irq_done) begin
                    state_d  = ST_IDLE;
                    in_irq_d = 1'b0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                req_d    = 1'b0;
                in_irq_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            src_q    <= '0;
            pend_q   <= '0;
            en_q     <= '0;
            state_q  <= ST_IDLE;
            req_q    <= 1'b0;
            vec_q    <= '0;
            act_q    <= '0;
            in_irq_q <= 1'b0;
        end else begin
            src_q    <= i_src;
            pend_q   <= pend_d;
            en_q     <= en_d;
            state_q  <= state_d;
            req_q    <= req_d;
            vec_q    <= vec_d;
            act_q    <= act_d;
            in_irq_q <= in_irq_d;
        end
    end

    // Read mux; bits above the implemented sources read as zero.
    always_comb begin
        o_rdata = '0;
        case (i_addr)
            IRQ_A_PEND: o_rdata[NUM_SRC-1:0] = pend_q;
            IRQ_A_EN:   o_rdata[NUM_SRC-1:0] = en_q;
            IRQ_A_STAT: o_rdata[VEC_W:0]     = {in_irq_q, act_q};
            default:    o_rdata              = '0;
        endcase
    end

    assign o_irq_req = req_q;
    assign o_irq_vec = vec_q;
    assign o_in_irq  = in_irq_q;

endmodule

// File: tb/tb_soc_irq_ctrl.sv
// Scoreboard bench for soc_irq_ctrl: directed scenarios plus randomized rounds against a behavioural model.
module tb_soc_irq_ctrl;

    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned VEC_W   = 3;

    localparam logic [1:0] A_PEND = 2'd0;
    localparam logic [1:0] A_EN   = 2'd1;
    localparam logic [1:0] A_STAT = 2'd2;
    localparam logic [1:0] A_SWI  = 2'd3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NUM_SRC-1:0] t_src = '0;
    logic               t_sel = 1'b0;
    logic               t_we = 1'b0;
    logic [1:0]         t_addr = '0;
    logic [DATA_W-1:0]  t_wdata = '0;
    logic [DATA_W-1:0]  o_rdata;
    logic               o_irq_req;
    logic [VEC_W-1:0]   o_irq_vec;
    logic               t_take = 1'b0;
    logic               t_done = 1'b0;
    logic               o_in_irq;

    soc_irq_ctrl #(
        .NUM_SRC (NUM_SRC),
        .DATA_W  (DATA_W),
        .VEC_W   (VEC_W)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_src      (t_src),
        .i_sel      (t_sel),
        .i_we       (t_we),
        .i_addr     (t_addr),
        .i_wdata    (t_wdata),
        .o_rdata    (o_rdata),
        .o_irq_req  (o_irq_req),
        .o_irq_vec  (o_irq_vec),
        .i_irq_take (t_take),
        .i_irq_done (t_done),
        .o_in_irq   (o_in_irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int    exp_vec_q[$];
    int    exp_rd_q[$];
    string exp_rd_name[$];

    // Behavioural model: pending/enable sets, last accepted source, active vector, in-service flag.
    bit [NUM_SRC-1:0] m_pend = '0;
    bit [NUM_SRC-1:0] m_en   = '0;
    int               m_last = NUM_SRC - 1;
    int               m_act  = 0;
    int               m_in   = 0;

    function automatic int model_winner();
        int idx;
        for (int k = 0; k < NUM_SRC; k++) begin
`ifdef IRQ_CTRL_RR_EN
            idx = (m_last + 1 + k) % NUM_SRC;
`else
            idx = k;
`endif
            if (m_pend[idx] && m_en[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: MMIO reads and every fresh request are checked against queued expectations.
    logic req_prev = 1'b0;
    always @(negedge clk) begin
        if (t_sel && !t_we) begin
            if (exp_rd_q.size() == 0) check("rd_unexpected", 1, 0);
            else check(exp_rd_name.pop_front(), int'(o_rdata), exp_rd_q.pop_front());
        end
        if (o_irq_req && !req_prev) begin
            if (exp_vec_q.size() == 0) check("req_unexpected", int'(o_irq_vec), -1);
            else check("irq_vec", int'(o_irq_vec), exp_vec_q.pop_front());
        end
        req_prev = o_irq_req;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input int d);
        t_sel = 1'b1; t_we = 1'b1; t_addr = a; t_wdata = DATA_W'(d);
        cyc();
        t_sel = 1'b0; t_we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input int exp, input string name);
        t_sel = 1'b1; t_we = 1'b0; t_addr = a;
        exp_rd_q.push_back(exp);
        exp_rd_name.push_back(name);
        cyc();
        t_sel = 1'b0;
    endtask

    task automatic pulse_src(input int bits);
        t_src = NUM_SRC'(bits);
        cyc();
        t_src = '0;
    endtask

    task automatic take_it();
        int w;
        w = int'(o_irq_vec);
        t_take = 1'b1;
        cyc();
        t_take = 1'b0;
        m_pend[w] = 1'b0;
        m_last = w;
        m_act = w;
        m_in = 1;
    endtask

    task automatic done_it();
        t_done = 1'b1;
        cyc();
        t_done = 1'b0;
        m_in = 0;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 30; i++) begin
            if (o_irq_req) return;
            cyc();
        end
        check("req_timeout", 0, 1);
    endtask

    task automatic model_reset();
        m_pend = '0; m_en = '0; m_last = NUM_SRC - 1; m_act = 0; m_in = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int bits;
        int en;
        int rr_seq[5];
        rr_seq = '{0, 1, 2, 3, 0};

        // Power-on reset
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        check("rst_req", int'(o_irq_req), 0);
        check("rst_in_irq", int'(o_in_irq), 0);
        rd(A_PEND, 0, "rst_pend");
        rd(A_EN, 0, "rst_en");
        rd(A_STAT, 0, "rst_stat");

        // Basic path with latency: req two edges after the source pulse
        wr(A_EN, 1); m_en = 4'b0001;
        m_pend[0] = 1'b1;
        exp_vec_q.push_back(model_winner());
        t_src = 4'b0001;
        cyc();
        t_src = '0;
        check("lat_req_early", int'(o_irq_req), 0);
        cyc();
        check("lat_req", int'(o_irq_req), 1);
        check("lat_vec", int'(o_irq_vec), 0);
        take_it();
        check("take_in_irq", int'(o_in_irq), 1);
        check("take_req_low", int'(o_irq_req), 0);
        rd(A_PEND, int'(m_pend), "take_pend");
        rd(A_STAT, 8 + m_act, "take_stat");
        done_it();
        check("done_in_irq", int'(o_in_irq), 0);

        // Priority and masking
        wr(A_EN, 4'b1010); m_en = 4'b1010;
        m_pend = m_pend | 4'b1110;
        exp_vec_q.push_back(model_winner());
        pulse_src(4'b1110);
        wait_req();
        check("prio_first", int'(o_irq_vec), 1);
        take_it();
        exp_vec_q.push_back(model_winner());
        done_it();
        wait_req();
        check("prio_second", int'(o_irq_vec), 3);
        take_it();
        done_it();
        repeat (3) cyc();
        check("masked_no_req", int'(o_irq_req), 0);
        rd(A_PEND, 4'b0100, "masked_pend");

        // W1C withdraw of an outstanding request, then a fresh request
        exp_vec_q.push_back(2);
        wr(A_EN, 4'b0100); m_en = 4'b0100;
        wait_req();
        wr(A_PEND, 4'b0100); m_pend[2] = 1'b0;
        cyc();
        check("withdraw_req", int'(o_irq_req), 0);
        rd(A_STAT, m_act, "withdraw_stat");
        m_pend[2] = 1'b1;
        exp_vec_q.push_back(model_winner());
        wr(A_SWI, 4'b0100);
        wait_req();
        take_it();
        done_it();

        // Collisions: W1C with same-cycle edge, done/take while idle
        wr(A_EN, 0); m_en = '0;
        t_src = 4'b0001;
        t_sel = 1'b1; t_we = 1'b1; t_addr = A_PEND; t_wdata = 16'h0001;
        cyc();
        t_src = '0; t_sel = 1'b0; t_we = 1'b0;
        m_pend[0] = 1'b1;
        rd(A_PEND, int'(m_pend), "collide_pend");
        done_it();
        check("idle_done_in_irq", int'(o_in_irq), 0);
        check("idle_done_req", int'(o_irq_req), 0);
        t_take = 1'b1; cyc(); t_take = 1'b0;
        check("idle_take_in_irq", int'(o_in_irq), 0);
        rd(A_STAT, m_act, "idle_stat");
        wr(A_PEND, 4'hF); m_pend = '0;

        // Reset while in service
        wr(A_EN, 4'hF); m_en = 4'hF;
        m_pend[1] = 1'b1;
        exp_vec_q.push_back(model_winner());
        wr(A_SWI, 4'b0010);
        wait_req();
        take_it();
        check("svc_in_irq", int'(o_in_irq), 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        model_reset();
        check("midrst_in_irq", int'(o_in_irq), 0);
        check("midrst_req", int'(o_irq_req), 0);
        rd(A_EN, 0, "midrst_en");
        rd(A_PEND, 0, "midrst_pend");

        // SWI all sources, repeated take/done: round-robin rotates, fixed priority repeats 0
        wr(A_EN, 4'hF); m_en = 4'hF;
        m_pend = 4'hF;
        wr(A_SWI, 4'hF);
        for (int i = 0; i < 5; i++) begin
            exp_vec_q.push_back(model_winner());
            wait_req();
`ifdef IRQ_CTRL_RR_EN
            check("swi_seq", int'(o_irq_vec), rr_seq[i]);
`else
            check("swi_seq", int'(o_irq_vec), 0);
`endif
            take_it();
            if (i < 4) begin
                wr(A_SWI, 4'hF); m_pend = 4'hF;
            end else begin
                wr(A_EN, 0); m_en = '0;
            end
            done_it();
        end
        wr(A_PEND, 4'hF); m_pend = '0;

        // Randomized rounds
        for (int r = 0; r < 30; r++) begin
            wr(A_EN, 0); m_en = '0;
            bits = int'($urandom_range(1, 15));
            if ($urandom % 2 == 0) pulse_src(bits);
            else wr(A_SWI, bits);
            m_pend = m_pend | NUM_SRC'(bits);
            en = int'($urandom_range(0, 15));
            exp_vec_q.push_back(-2);
            void'(exp_vec_q.pop_back());
            m_en = NUM_SRC'(en);
            if (model_winner() >= 0) exp_vec_q.push_back(model_winner());
            wr(A_EN, en);
            while (model_winner() >= 0) begin
                wait_req();
                take_it();
                w = m_act;
                check("rnd_in_irq", int'(o_in_irq), 1);
                rd(A_STAT, 8 + w, "rnd_stat");
                if (model_winner() >= 0) exp_vec_q.push_back(model_winner());
                done_it();
                check("rnd_done", int'(o_in_irq), 0);
            end
            rd(A_PEND, int'(m_pend), "rnd_pend");
        end

        repeat (5) cyc();
        check("vec_queue_drained", exp_vec_q.size(), 0);
        check("rd_queue_drained", exp_rd_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
